wb_port_arbiter: RTL and testbench

Shares one scoreboard writeback port (trans_id/wbdata/ex/wt_valid) between NR_REQ functional-unit result sources, e.g. multiplier, CSR buffer and accelerator response. Round-robin arbitration feeds a one-entry registered output stage with valid/ready toward the issue stage writeback inputs. It sits between the execute-stage units and one slot of the issue stage's writeback ports.

---
 rtl/wb_port_arbiter_pkg.sv | 14 +
 rtl/wb_port_arbiter_rr_pick.sv | 39 +++
 rtl/wb_port_arbiter.sv | 77 +++++++
 tb/tb_wb_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the writeback port arbiter slice. These mirror the
// ariane_pkg / riscv subset the arbiter uses, so the slice builds on its own.
package wb_port_arbiter_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

endpackage

// File: rtl/wb_port_arbiter_rr_pick.sv
// Combinational round-robin scan: first valid requester at or after ptr,
// wrapping modulo NR_REQ.
module wb_port_arbiter_rr_pick #(
  parameter int unsigned NR_REQ = 3,
  parameter int unsigned IDX_W  = $clog2(NR_REQ)
) (
  input  logic [NR_REQ-1:0] valid,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NR_REQ-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              any_valid
);

  logic [2*NR_REQ-1:0] dbl;
  logic [NR_REQ-1:0]   rot;
  logic                found;
  int unsigned         off;
  int unsigned         sum;

  // Rotate so that ptr sits at bit 0; a fixed-priority scan then gives the RR order.
  always_comb begin
    dbl   = {valid, valid} >> ptr;
    rot   = dbl[NR_REQ-1:0];
    found = 1'b0;
    off   = 0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    sum = 32'(ptr) + off;
    if (sum >= NR_REQ) sum = sum - NR_REQ;
    idx       = IDX_W'(sum);
    gnt       = found ? ((NR_REQ)'(1) << idx) : '0;
    any_valid = |valid;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one scoreboard writeback port between NR_REQ
// result sources, with a one-entry registered output stage.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ       = 3,
  parameter int unsigned RR_RESET_IDX = 0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic [NR_REQ-1:0]                     req_valid_i,
  output logic [NR_REQ-1:0]                     req_ready_o,
  input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]  req_trans_id_i,
  input  logic [NR_REQ-1:0][XLEN-1:0]           req_data_i,
  input  exception_t [NR_REQ-1:0]               req_ex_i,
  input  logic                                  wb_ready_i,
  output logic                                  wt_valid_o,
  output logic [TRANS_ID_BITS-1:0]              trans_id_o,
  output logic [XLEN-1:0]                       wbdata_o,
  output exception_t                            ex_o,
  output logic [$clog2(NR_REQ)-1:0]             grant_idx_o
);

  localparam int unsigned IDX_W = $clog2(NR_REQ);

  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  ptr_next;
  logic [NR_REQ-1:0] gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              any_valid;
  logic              load;
  logic              grant_en;

  wb_port_arbiter_rr_pick #(
    .NR_REQ (NR_REQ),
    .IDX_W  (IDX_W)
  ) i_rr_pick (
    .valid     (req_valid_i),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .idx       (pick_idx),
    .any_valid (any_valid)
  );

  always_comb begin
    load        = !wt_valid_o || wb_ready_i;
    grant_en    = load && !flush_i && !rst_i && any_valid;
    req_ready_o = grant_en ? gnt : '0;
    ptr_next    = (pick_idx == IDX_W'(NR_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wt_valid_o  <= 1'b0;
      trans_id_o  <= '0;
      wbdata_o    <= '0;
      ex_o        <= '0;
      grant_idx_o <= '0;
      ptr_q       <= IDX_W'(RR_RESET_IDX);
    end else if (flush_i) begin
      wt_valid_o <= 1'b0;
    end else if (load) begin
      if (any_valid) begin
        wt_valid_o  <= 1'b1;
        trans_id_o  <= req_trans_id_i[pick_idx];
        wbdata_o    <= req_data_i[pick_idx];
        ex_o        <= req_ex_i[pick_idx];
        grant_idx_o <= pick_idx;
        ptr_q       <= ptr_next;
      end else begin
        wt_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level round-robin reference model.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int N       = 3;
  localparam int RST_IDX = 0;

  logic                                 clk = 1'b0;
  logic                                 rst, flush, wb_ready;
  logic [N-1:0]                         req_valid, req_ready;
  logic [N-1:0][TRANS_ID_BITS-1:0]      req_tid;
  logic [N-1:0][XLEN-1:0]               req_data;
  exception_t [N-1:0]                   req_ex;
  logic                                 wt_valid;
  logic [TRANS_ID_BITS-1:0]             trans_id;
  logic [XLEN-1:0]                      wbdata;
  exception_t                           ex;
  logic [$clog2(N)-1:0]                 grant_idx;

  int checks = 0;
  int errors = 0;

  // Reference model state: the held result and the next-priority requester.
  bit                       m_valid = 0;
  logic [TRANS_ID_BITS-1:0] m_tid   = '0;
  logic [XLEN-1:0]          m_data  = '0;
  exception_t               m_ex    = '0;
  int                       m_idx   = 0;
  int                       m_ptr   = RST_IDX;

  wb_port_arbiter #(
    .NR_REQ       (N),
    .RR_RESET_IDX (RST_IDX)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_trans_id_i (req_tid),
    .req_data_i     (req_data),
    .req_ex_i       (req_ex),
    .wb_ready_i     (wb_ready),
    .wt_valid_o     (wt_valid),
    .trans_id_o     (trans_id),
    .wbdata_o       (wbdata),
    .ex_o           (ex),
    .grant_idx_o    (grant_idx)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int j = (p + k) % N;
      for (int b = 0; b < N; b++)
        if (b == j && v[b]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] one = 1;
    return (w < 0) ? '0 : (one << w);
  endfunction

  function automatic logic [N-1:0] exp_ready();
    if (rst || flush || (m_valid && !wb_ready)) return '0;
    return onehot(pick(req_valid, m_ptr));
  endfunction

  task automatic model_edge();
    int w;
    if (rst) begin
      m_valid = 0; m_tid = '0; m_data = '0; m_ex = '0; m_idx = 0; m_ptr = RST_IDX;
    end else if (flush) begin
      m_valid = 0;
    end else if (!m_valid || wb_ready) begin
      w = pick(req_valid, m_ptr);
      if (w >= 0) begin
        m_valid = 1; m_tid = req_tid[w]; m_data = req_data[w]; m_ex = req_ex[w];
        m_idx = w; m_ptr = (w + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; wb_ready = 0; req_valid = '0;
    req_tid = '0; req_data = '0; req_ex = '0;
    @(negedge clk);
    tick(); tick();
    rst = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (wt_valid !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: wt_valid=%b req_ready=%b, required 0/000", c, wt_valid, req_ready);
      end
      checks++;
      if (trans_id !== '0 || wbdata !== '0 || ex !== '0 || grant_idx !== '0) begin
        errors++;
        $display("FAIL reset_fields: tid=%0d data=%h exv=%b gidx=%0d, required all 0", trans_id, wbdata, ex.valid, grant_idx);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    req_tid[0] = 3'd1; req_tid[1] = 3'd2; req_tid[2] = 3'd3;
    req_valid = 3'b111; wb_ready = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (req_ready !== onehot(k % 3)) begin
        errors++;
        $display("FAIL rr_grant k=%0d: req_ready=%b, required %b", k, req_ready, onehot(k % 3));
      end
      if (k >= 1) begin
        checks++;
        if (wt_valid !== 1'b1 || trans_id !== 3'((k - 1) % 3 + 1)) begin
          errors++;
          $display("FAIL rr_output k=%0d: wt_valid=%b tid=%0d, required 1/%0d", k, wt_valid, trans_id, (k - 1) % 3 + 1);
        end
      end
      tick();
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_stall();
    req_valid = 3'b100; req_data[2] = 64'hDEAD_BEEF; req_tid[2] = 3'd5; wb_ready = 0;
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      errors++;
      $display("FAIL stall_grant: req_ready=%b, required 100", req_ready);
    end
    tick();
    req_valid = 3'b111;
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++;
      if (wt_valid !== 1'b1 || wbdata !== 64'hDEAD_BEEF || grant_idx !== 2'd2 || trans_id !== 3'd5) begin
        errors++;
        $display("FAIL stall_hold s=%0d: v=%b data=%h gidx=%0d tid=%0d, required 1/deadbeef/2/5", s, wt_valid, wbdata, grant_idx, trans_id);
      end
      checks++;
      if (req_ready !== 3'b000) begin
        errors++;
        $display("FAIL stall_ready s=%0d: req_ready=%b, required 000", s, req_ready);
      end
      tick();
    end
    wb_ready = 1;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL stall_drain_grant: req_ready=%b, required 001", req_ready);
    end
    tick();
    #1;
    checks++;
    if (wt_valid !== 1'b1 || trans_id !== 3'd1 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL stall_drain_next: v=%b tid=%0d gidx=%0d, required 1/1/0", wt_valid, trans_id, grant_idx);
    end
    req_valid = '0;
    tick(); tick();
  endtask

  task automatic test_flush();
    req_valid = 3'b010; req_tid[1] = 3'd4; wb_ready = 0;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++;
      $display("FAIL flush_setup_grant: req_ready=%b, required 010", req_ready);
    end
    tick();
    req_valid = 3'b111; flush = 1;
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++;
      $display("FAIL flush_no_grant: req_ready=%b, required 000", req_ready);
    end
    tick();
    flush = 0;
    #1;
    checks++;
    if (wt_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: wt_valid=%b, required 0", wt_valid);
    end
    // Priority after granting idx 1 is idx 2, untouched by the flush.
    checks++;
    if (req_ready !== 3'b100) begin
      errors++;
      $display("FAIL flush_ptr_kept: req_ready=%b, required 100", req_ready);
    end
    tick();
    #1;
    checks++;
    if (wt_valid !== 1'b1 || grant_idx !== 2'd2) begin
      errors++;
      $display("FAIL flush_next_load: v=%b gidx=%0d, required 1/2", wt_valid, grant_idx);
    end
    req_valid = '0; wb_ready = 1;
    tick();
  endtask

  task automatic test_exception();
    exception_t e;
    e = '0; e.cause = 64'd5; e.tval = 64'h1234; e.valid = 1'b1;
    req_ex[1] = e; req_tid[1] = 3'd6; req_valid = 3'b010; wb_ready = 1;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++;
      $display("FAIL ex_grant: req_ready=%b, required 010", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (ex.valid !== 1'b1 || ex.cause !== 64'd5 || ex.tval !== 64'h1234 || trans_id !== 3'd6 || grant_idx !== 2'd1) begin
      errors++;
      $display("FAIL ex_forward: exv=%b cause=%0d tval=%h tid=%0d gidx=%0d, required 1/5/1234/6/1", ex.valid, ex.cause, ex.tval, trans_id, grant_idx);
    end
    tick();
    req_ex = '0;
  endtask

  task automatic test_reset_midstream();
    req_data[0] = 64'hA; req_data[1] = 64'hB; req_data[2] = 64'hC;
    req_valid = 3'b111; wb_ready = 1;
    tick(); tick();
    rst = 1; flush = 1;
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++;
      $display("FAIL rst_ready: req_ready=%b, required 000", req_ready);
    end
    tick();
    rst = 0; flush = 0;
    #1;
    checks++;
    if (wt_valid !== 1'b0 || trans_id !== '0 || wbdata !== '0 || ex !== '0 || grant_idx !== '0) begin
      errors++;
      $display("FAIL rst_outputs: v=%b tid=%0d data=%h gidx=%0d, required all 0", wt_valid, trans_id, wbdata, grant_idx);
    end
    checks++;
    if (req_ready !== onehot(RST_IDX)) begin
      errors++;
      $display("FAIL rst_first_grant: req_ready=%b, required %b", req_ready, onehot(RST_IDX));
    end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] acc;
    for (int c = 0; c < 400; c++) begin
      #1;
      checks++;
      if (req_ready !== exp_ready()) begin
        errors++;
        $display("FAIL rand_ready c=%0d: req_ready=%b, required %b", c, req_ready, exp_ready());
      end
      checks++;
      if (wt_valid !== m_valid || trans_id !== m_tid || wbdata !== m_data || ex !== m_ex || grant_idx !== 2'(m_idx)) begin
        errors++;
        $display("FAIL rand_out c=%0d: v=%b tid=%0d data=%h gidx=%0d, required %b/%0d/%h/%0d",
                 c, wt_valid, trans_id, wbdata, grant_idx, m_valid, m_tid, m_data, m_idx);
      end
      acc = exp_ready();
      tick();
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !acc[i])) begin
          req_valid[i]    = ($urandom_range(0, 9) < 6);
          req_tid[i]      = 3'($urandom);
          req_data[i]     = {$urandom, $urandom};
          req_ex[i].cause = {$urandom, $urandom};
          req_ex[i].tval  = {$urandom, $urandom};
          req_ex[i].valid = 1'($urandom);
        end
      end
      wb_ready = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 49) == 0);
    end
    rst = 0; flush = 0; req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_flush();
    test_exception();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
